// File: rtl/game_select_ctrl_if.sv
// Front-panel button and game-select status bundle between the panel side
// (master: drives buttons) and game_select_ctrl (slave: drives the select outputs).
interface game_select_ctrl_if;
  logic       btn_up;
  logic       btn_dn;
  logic       btn_sel;
  logic       btn_back;
  logic [2:0] ctrl;
  logic [2:0] cursor;
  logic       menu_active;
  logic       game_start;
  logic       exit_pulse;

  modport master (
    output btn_up, btn_dn, btn_sel, btn_back,
    input  ctrl, cursor, menu_active, game_start, exit_pulse
  );

  modport slave (
    input  btn_up, btn_dn, btn_sel, btn_back,
    output ctrl, cursor, menu_active, game_start, exit_pulse
  );
endinterface

// File: rtl/game_select_ctrl.sv
// Menu/game-launch controller feeding the top-level game multiplexer.
// Optional build macro CURSOR_WRAP_EN: cursor wraps at both ends instead of saturating.
module game_select_ctrl #(
  parameter int NUM_GAMES   = 5,
  parameter int DB_CYCLES   = 1000000,
  parameter int HOLD_CYCLES = 200000000
) (
  input  logic              sys_clk,
  input  logic              reset,
  game_select_ctrl_if.slave gs
);

  localparam int NB     = 4;
  localparam int BTN_UP = 0;
  localparam int BTN_DN = 1;
  localparam int BTN_SL = 2;
  localparam int BTN_BK = 3;

  localparam int DB_W   = $clog2(DB_CYCLES + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [2:0]        ID_MIN    = 3'd1;
  localparam logic [2:0]        ID_MAX    = 3'(NUM_GAMES);

`ifdef CURSOR_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_MENU,
    S_LAUNCH,
    S_PLAY,
    S_EXIT
  } state_e;

  // ---------------------------------------------------------------------------
  // Synchronisers and debouncers, one lane per button
  // ---------------------------------------------------------------------------
  logic [NB-1:0]   btn_raw;
  logic [NB-1:0]   sync1_q, sync2_q;
  logic [NB-1:0]   stable_q, stable_d;
  logic [NB-1:0]   press_q, press_d;
  logic [DB_W-1:0] db_cnt_q [NB];
  logic [DB_W-1:0] db_cnt_d [NB];

  assign btn_raw = {gs.btn_back, gs.btn_sel, gs.btn_dn, gs.btn_up};

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned and a latch can never be inferred.
  always_comb begin
    for (int i = 0; i < NB; i++) begin
      stable_d[i] = stable_q[i];
      press_d[i]  = 1'b0;
      db_cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          stable_d[i] = sync2_q[i];
          press_d[i]  = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge value of its neighbours.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      press_q  <= '0;
      for (int i = 0; i < NB; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q  <= btn_raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      press_q  <= press_d;
      for (int i = 0; i < NB; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  logic up_p, dn_p, sel_p, back_lvl;

  assign up_p     = press_q[BTN_UP];
  assign dn_p     = press_q[BTN_DN];
  assign sel_p    = press_q[BTN_SL];
  assign back_lvl = stable_q[BTN_BK];

  // ---------------------------------------------------------------------------
  // Menu / launch / play / exit FSM with registered outputs
  // ---------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [2:0]        cursor_q, cursor_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              back_armed_q, back_armed_d;
  logic [2:0]        ctrl_q, ctrl_d;
  logic              menu_active_q, menu_active_d;
  logic              game_start_q, game_start_d;
  logic              exit_pulse_q, exit_pulse_d;

  always_comb begin
    state_d      = state_q;
    cursor_d     = cursor_q;
    hold_d       = '0;
    // A back press that caused an exit must be released before it can count again.
    back_armed_d = back_armed_q | ~back_lvl;

    case (state_q)
      S_MENU: begin
        if (sel_p) begin
          state_d = S_LAUNCH;
        end else if (up_p && !dn_p) begin
          cursor_d = (cursor_q == ID_MIN) ? (WRAP_EN ? ID_MAX : ID_MIN)
                                          : cursor_q - 3'd1;
        end else if (dn_p && !up_p) begin
          cursor_d = (cursor_q == ID_MAX) ? (WRAP_EN ? ID_MIN : ID_MAX)
                                          : cursor_q + 3'd1;
        end
      end

      S_LAUNCH: state_d = S_PLAY;

      S_PLAY: begin
        if (back_lvl && back_armed_q) begin
          if (hold_q == HOLD_LAST) begin
            state_d      = S_EXIT;
            back_armed_d = 1'b0;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
      end

      S_EXIT:  state_d = S_MENU;

      default: state_d = S_MENU;
    endcase

    // Outputs follow the state being entered so they change on that same edge.
    ctrl_d        = (state_d == S_PLAY) ? cursor_d : 3'd0;
    menu_active_d = (state_d == S_MENU) || (state_d == S_LAUNCH);
    game_start_d  = (state_d == S_LAUNCH);
    exit_pulse_d  = (state_d == S_EXIT);
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q       <= S_MENU;
      cursor_q      <= ID_MIN;
      hold_q        <= '0;
      back_armed_q  <= 1'b1;
      ctrl_q        <= 3'd0;
      menu_active_q <= 1'b1;
      game_start_q  <= 1'b0;
      exit_pulse_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cursor_q      <= cursor_d;
      hold_q        <= hold_d;
      back_armed_q  <= back_armed_d;
      ctrl_q        <= ctrl_d;
      menu_active_q <= menu_active_d;
      game_start_q  <= game_start_d;
      exit_pulse_q  <= exit_pulse_d;
    end
  end

  assign gs.ctrl        = ctrl_q;
  assign gs.cursor      = cursor_q;
  assign gs.menu_active = menu_active_q;
  assign gs.game_start  = game_start_q;
  assign gs.exit_pulse  = exit_pulse_q;

endmodule

// File: tb/tb_game_select_ctrl.sv
// Self-checking bench for game_select_ctrl: directed scenarios plus randomized
// menu navigation checked against a rule-level cursor model.
module tb_game_select_ctrl;

  localparam int NG   = 5;
  localparam int DB   = 4;
  localparam int HOLD = 16;

`ifdef CURSOR_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic sys_clk = 1'b0;
  logic reset;

  game_select_ctrl_if gs ();

  game_select_ctrl #(
    .NUM_GAMES  (NG),
    .DB_CYCLES  (DB),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .sys_clk(sys_clk),
    .reset  (reset),
    .gs     (gs)
  );

  always #5 sys_clk = ~sys_clk;

  int vectors = 0;
  int errors  = 0;
  int m_cursor = 1;

  // Cursor rule: simultaneous up/dn is a no-op; ends saturate or wrap.
  function automatic int model_move(input int cur, input bit up, input bit dn);
    if (up && dn) return cur;
    if (up) return (cur == 1)  ? (WRAP ? NG : 1) : cur - 1;
    if (dn) return (cur == NG) ? (WRAP ? 1 : NG) : cur + 1;
    return cur;
  endfunction

  task automatic drive_press(input bit u, input bit d, input bit s,
                             input int hold_cyc, input int gap_cyc);
    gs.btn_up = u; gs.btn_dn = d; gs.btn_sel = s;
    repeat (hold_cyc) @(negedge sys_clk);
    gs.btn_up = 1'b0; gs.btn_dn = 1'b0; gs.btn_sel = 1'b0;
    repeat (gap_cyc) @(negedge sys_clk);
  endtask

  task automatic do_launch(input bit with_up, output int n_start, output int lat,
                           output logic [2:0] ctrl_at_start, output logic [2:0] ctrl_next);
    n_start = 0; lat = -1; ctrl_at_start = 'x; ctrl_next = 'x;
    gs.btn_sel = 1'b1; gs.btn_up = with_up;
    for (int c = 1; c <= 25; c++) begin
      @(negedge sys_clk);
      if (c == 10) begin gs.btn_sel = 1'b0; gs.btn_up = 1'b0; end
      if (lat > 0 && c == lat + 1) ctrl_next = gs.ctrl;
      if (gs.game_start === 1'b1) begin n_start++; lat = c; ctrl_at_start = gs.ctrl; end
    end
  endtask

  task automatic do_hold_back(input int hold_cyc, output int n_exit,
                              output logic [2:0] ctrl_at_exit, output int n_ctrl_moves);
    logic [2:0] prev;
    n_exit = 0; ctrl_at_exit = 'x; n_ctrl_moves = 0; prev = gs.ctrl;
    gs.btn_back = 1'b1;
    for (int c = 1; c <= hold_cyc + 12; c++) begin
      @(negedge sys_clk);
      if (c == hold_cyc) gs.btn_back = 1'b0;
      if (gs.exit_pulse === 1'b1) begin n_exit++; ctrl_at_exit = gs.ctrl; end
      if (gs.ctrl !== prev) n_ctrl_moves++;
      prev = gs.ctrl;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge sys_clk);
    vectors++;
    if ({gs.ctrl, gs.cursor, gs.menu_active, gs.game_start, gs.exit_pulse} !== {3'd0, 3'd1, 3'b100}) begin
      errors++;
      $display("FAIL reset_state: got ctrl=%0d cursor=%0d menu=%b start=%b exit=%b, want 0/1/1/0/0",
               gs.ctrl, gs.cursor, gs.menu_active, gs.game_start, gs.exit_pulse);
    end
    reset = 1'b0;
    @(negedge sys_clk);
    // Two-cycle sel glitch must be rejected by the debouncer.
    gs.btn_sel = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge sys_clk);
      if (c == 2) gs.btn_sel = 1'b0;
      vectors++;
      if ({gs.ctrl, gs.cursor, gs.menu_active, gs.game_start} !== {3'd0, 3'd1, 2'b10}) begin
        errors++;
        $display("FAIL short_sel_cycle%0d: got ctrl=%0d cursor=%0d menu=%b start=%b, want 0/1/1/0",
                 c, gs.ctrl, gs.cursor, gs.menu_active, gs.game_start);
      end
    end
    m_cursor = 1;
  endtask

  task automatic test_launch();
    int n, lat;
    logic [2:0] c0, c1;
    for (int k = 0; k < 2; k++) begin
      drive_press(1'b0, 1'b1, 1'b0, 10, 10);
      m_cursor = model_move(m_cursor, 1'b0, 1'b1);
      vectors++;
      if (gs.cursor !== 3'(m_cursor)) begin
        errors++;
        $display("FAIL dn_press%0d: cursor=%0d want %0d", k, gs.cursor, m_cursor);
      end
    end
    do_launch(1'b0, n, lat, c0, c1);
    vectors++;
    if (n !== 1) begin errors++; $display("FAIL launch_start_count: got %0d want 1", n); end
    vectors++;
    if (lat < 2 + DB || lat > 2 + DB + 2) begin
      errors++; $display("FAIL launch_latency: got %0d want %0d..%0d", lat, 2 + DB, 2 + DB + 2);
    end
    vectors++;
    if (c0 !== 3'd0) begin errors++; $display("FAIL ctrl_during_start: got %0d want 0", c0); end
    vectors++;
    if (c1 !== 3'd3) begin errors++; $display("FAIL ctrl_after_start: got %0d want 3", c1); end
    vectors++;
    if ({gs.ctrl, gs.cursor, gs.menu_active} !== {3'd3, 3'd3, 1'b0}) begin
      errors++;
      $display("FAIL play_state: got ctrl=%0d cursor=%0d menu=%b want 3/3/0", gs.ctrl, gs.cursor, gs.menu_active);
    end
  endtask

  task automatic test_play_lockout();
    int n_exit, moves;
    logic [2:0] ce;
    for (int b = 0; b < 3; b++) begin
      drive_press(b == 0, b == 1, b == 2, 10, 10);
      vectors++;
      if ({gs.ctrl, gs.cursor, gs.menu_active} !== {3'd3, 3'd3, 1'b0}) begin
        errors++;
        $display("FAIL play_ignore_btn%0d: got ctrl=%0d cursor=%0d menu=%b want 3/3/0",
                 b, gs.ctrl, gs.cursor, gs.menu_active);
      end
    end
    do_hold_back(30, n_exit, ce, moves);
    vectors++;
    if (n_exit !== 1) begin errors++; $display("FAIL exit_count: got %0d want 1", n_exit); end
    vectors++;
    if (ce !== 3'd0) begin errors++; $display("FAIL ctrl_at_exit: got %0d want 0", ce); end
    vectors++;
    if ({gs.ctrl, gs.cursor, gs.menu_active} !== {3'd0, 3'd3, 1'b1}) begin
      errors++;
      $display("FAIL after_exit: got ctrl=%0d cursor=%0d menu=%b want 0/3/1", gs.ctrl, gs.cursor, gs.menu_active);
    end
  endtask

  task automatic test_hold_clear();
    int n, lat, n_exit, moves;
    logic [2:0] c0, c1, ce;
    do_launch(1'b0, n, lat, c0, c1);
    vectors++;
    if (gs.ctrl !== 3'(m_cursor)) begin errors++; $display("FAIL relaunch: ctrl=%0d want %0d", gs.ctrl, m_cursor); end
    for (int k = 0; k < 2; k++) begin
      do_hold_back(10, n_exit, ce, moves);
      vectors++;
      if (n_exit !== 0 || moves !== 0) begin
        errors++;
        $display("FAIL short_hold%0d: exits=%0d ctrl_moves=%0d want 0/0", k, n_exit, moves);
      end
    end
    vectors++;
    if (gs.ctrl !== 3'(m_cursor)) begin errors++; $display("FAIL short_hold_ctrl: ctrl=%0d want %0d", gs.ctrl, m_cursor); end
    do_hold_back(30, n_exit, ce, moves);
    vectors++;
    if (n_exit !== 1 || gs.menu_active !== 1'b1) begin
      errors++; $display("FAIL long_hold_exit: exits=%0d menu=%b want 1/1", n_exit, gs.menu_active);
    end
  endtask

  task automatic test_back_rearm();
    int n, lat, n_exit, moves;
    logic [2:0] c0, c1, ce;
    do_launch(1'b0, n, lat, c0, c1);
    gs.btn_back = 1'b1;
    repeat (30) @(negedge sys_clk);
    vectors++;
    if ({gs.ctrl, gs.menu_active} !== {3'd0, 1'b1}) begin
      errors++; $display("FAIL held_exit: ctrl=%0d menu=%b want 0/1", gs.ctrl, gs.menu_active);
    end
    // Launch again with back still held: the stale hold must not exit.
    drive_press(1'b0, 1'b0, 1'b1, 10, 10);
    repeat (30) @(negedge sys_clk);
    vectors++;
    if ({gs.ctrl, gs.menu_active} !== {3'(m_cursor), 1'b0}) begin
      errors++; $display("FAIL stale_back: ctrl=%0d menu=%b want %0d/0", gs.ctrl, gs.menu_active, m_cursor);
    end
    gs.btn_back = 1'b0;
    repeat (12) @(negedge sys_clk);
    do_hold_back(30, n_exit, ce, moves);
    vectors++;
    if (n_exit !== 1 || gs.ctrl !== 3'd0) begin
      errors++; $display("FAIL rearmed_exit: exits=%0d ctrl=%0d want 1/0", n_exit, gs.ctrl);
    end
  endtask

  task automatic test_cursor_ends();
    for (int k = 0; k < 8 && m_cursor != 1; k++) begin
      drive_press(1'b1, 1'b0, 1'b0, 10, 10);
      m_cursor = model_move(m_cursor, 1'b1, 1'b0);
    end
    vectors++;
    if (gs.cursor !== 3'd1) begin errors++; $display("FAIL reach_min: cursor=%0d want 1", gs.cursor); end
    drive_press(1'b1, 1'b0, 1'b0, 10, 10);
    m_cursor = model_move(m_cursor, 1'b1, 1'b0);
    vectors++;
    if (gs.cursor !== 3'(m_cursor)) begin errors++; $display("FAIL up_at_min: cursor=%0d want %0d", gs.cursor, m_cursor); end
    for (int k = 0; k < 8 && m_cursor != NG; k++) begin
      drive_press(1'b0, 1'b1, 1'b0, 10, 10);
      m_cursor = model_move(m_cursor, 1'b0, 1'b1);
    end
    drive_press(1'b0, 1'b1, 1'b0, 10, 10);
    m_cursor = model_move(m_cursor, 1'b0, 1'b1);
    vectors++;
    if (gs.cursor !== 3'(m_cursor)) begin errors++; $display("FAIL dn_at_max: cursor=%0d want %0d", gs.cursor, m_cursor); end
  endtask

  task automatic test_sel_priority_reset();
    int n, lat;
    logic [2:0] c0, c1;
    for (int k = 0; k < 8 && m_cursor != 2; k++) begin
      drive_press(m_cursor > 2, m_cursor < 2, 1'b0, 10, 10);
      m_cursor = model_move(m_cursor, m_cursor > 2, m_cursor < 2);
    end
    do_launch(1'b1, n, lat, c0, c1);
    vectors++;
    if ({gs.ctrl, gs.cursor, gs.menu_active} !== {3'd2, 3'd2, 1'b0} || n !== 1) begin
      errors++;
      $display("FAIL sel_priority: ctrl=%0d cursor=%0d menu=%b starts=%0d want 2/2/0/1",
               gs.ctrl, gs.cursor, gs.menu_active, n);
    end
    reset = 1'b1;
    @(negedge sys_clk);
    vectors++;
    if ({gs.ctrl, gs.cursor, gs.menu_active} !== {3'd0, 3'd1, 1'b1}) begin
      errors++;
      $display("FAIL midgame_reset: ctrl=%0d cursor=%0d menu=%b want 0/1/1", gs.ctrl, gs.cursor, gs.menu_active);
    end
    reset = 1'b0;
    m_cursor = 1;
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic test_random();
    int n, lat, n_exit, moves, op, glen, which;
    logic [2:0] c0, c1, ce;
    for (int k = 1; k <= 30; k++) begin
      op = $urandom_range(0, 3);
      if (op == 3) begin
        glen  = $urandom_range(1, 3);
        which = $urandom_range(0, 3);
        gs.btn_up = (which == 0); gs.btn_dn = (which == 1);
        gs.btn_sel = (which == 2); gs.btn_back = (which == 3);
        repeat (glen) @(negedge sys_clk);
        gs.btn_up = 0; gs.btn_dn = 0; gs.btn_sel = 0; gs.btn_back = 0;
        repeat (10) @(negedge sys_clk);
      end else begin
        drive_press(op != 1, op != 0, 1'b0, $urandom_range(6, 12), $urandom_range(8, 12));
        m_cursor = model_move(m_cursor, op != 1, op != 0);
      end
      vectors++;
      if ({gs.ctrl, gs.cursor, gs.menu_active} !== {3'd0, 3'(m_cursor), 1'b1}) begin
        errors++;
        $display("FAIL rand_move%0d op%0d: ctrl=%0d cursor=%0d menu=%b want 0/%0d/1",
                 k, op, gs.ctrl, gs.cursor, gs.menu_active, m_cursor);
      end
      if (k % 10 == 0) begin
        do_launch(1'b0, n, lat, c0, c1);
        vectors++;
        if (n !== 1 || c1 !== 3'(m_cursor)) begin
          errors++; $display("FAIL rand_launch%0d: starts=%0d ctrl=%0d want 1/%0d", k, n, c1, m_cursor);
        end
        do_hold_back($urandom_range(24, 32), n_exit, ce, moves);
        vectors++;
        if (n_exit !== 1 || gs.ctrl !== 3'd0 || gs.cursor !== 3'(m_cursor)) begin
          errors++;
          $display("FAIL rand_exit%0d: exits=%0d ctrl=%0d cursor=%0d want 1/0/%0d",
                   k, n_exit, gs.ctrl, gs.cursor, m_cursor);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    gs.btn_up = 1'b0; gs.btn_dn = 1'b0; gs.btn_sel = 1'b0; gs.btn_back = 1'b0;
    @(negedge sys_clk);
    test_reset();
    test_launch();
    test_play_lockout();
    test_hold_clear();
    test_back_rearm();
    test_cursor_ends();
    test_sel_priority_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
    $fatal(1, "time limit");
  end

endmodule
